// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: redirect input, 64-bit memory read channel and the
// decoder-facing instruction queue head.
`timescale 1ns/1ps
interface instr_fetch_if #(
  parameter int INSTRSZ = 32,
  parameter int ADDRSZ  = 64
);
  logic               redirect_valid;
  logic [ADDRSZ-1:0]  redirect_pc;
  logic               mem_req_valid;
  logic [ADDRSZ-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [63:0]        mem_resp_data;
  logic               instr_valid;
  logic [INSTRSZ-1:0] instr;
  logic [ADDRSZ-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: issues 8-byte aligned reads, splits each response into
// 32-bit instructions and queues them for the decoder.
//
//   state  | meaning
//   S_REQ  | may issue a read when the queue has room for two entries
//   S_WAIT | one read outstanding, its response will be queued
//   S_DROP | one read outstanding, its response is stale and discarded
`timescale 1ns/1ps
module instr_fetch #(
  parameter int                INSTRSZ  = 32,
  parameter int                ADDRSZ   = 64,
  parameter int                DEPTH    = 4,
  parameter logic [ADDRSZ-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDRSZ-1:0]  fetch_pc;
  logic [ADDRSZ-1:0]  line_addr;
  logic [INSTRSZ-1:0] q_instr [DEPTH];
  logic [ADDRSZ-1:0]  q_pc    [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               req_fire;
  logic               resp_take;
  logic               pop;
  logic [1:0]         push_n;

  assign line_addr        = {fetch_pc[ADDRSZ-1:3], 3'b000};
  assign bus.mem_req_addr = line_addr;
  assign req_fire         = bus.mem_req_valid && bus.mem_req_ready;
  assign pop              = bus.instr_valid && bus.instr_ready;
  // An odd-word fetch PC keeps only the upper half of the line.
  assign push_n           = resp_take ? (fetch_pc[2] ? 2'd1 : 2'd2) : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (req_fire) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mem_resp_valid)      state_nxt = S_REQ;
        else if (bus.redirect_valid) state_nxt = S_DROP;
      end
      S_DROP:  if (bus.mem_resp_valid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.instr_valid   = 1'b0;
    bus.instr         = '0;
    bus.instr_pc      = '0;
    resp_take         = 1'b0;
    if (!reset) begin
      bus.mem_req_valid = (state == S_REQ) && (count <= CW'(DEPTH - 2)) && !bus.redirect_valid;
      resp_take         = (state == S_WAIT) && bus.mem_resp_valid && !bus.redirect_valid;
      if (count != '0) begin
        bus.instr_valid = 1'b1;
        bus.instr       = q_instr[rd_ptr];
        bus.instr_pc    = q_pc[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~ADDRSZ'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (resp_take) fetch_pc <= line_addr + ADDRSZ'(8);
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_take) begin
      if (fetch_pc[2]) begin
        q_instr[wr_ptr] <= INSTRSZ'(bus.mem_resp_data[63:32]);
        q_pc[wr_ptr]    <= fetch_pc;
      end else begin
        q_instr[wr_ptr]          <= INSTRSZ'(bus.mem_resp_data[31:0]);
        q_pc[wr_ptr]             <= fetch_pc;
        q_instr[wr_ptr + PW'(1)] <= INSTRSZ'(bus.mem_resp_data[63:32]);
        q_pc[wr_ptr + PW'(1)]    <= fetch_pc + ADDRSZ'(4);
      end
    end
  end
endmodule
